// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter in front of a shared multi-cycle parity engine.
// One requester is granted at a time. Its result comes back tagged with the requester index.
module parity_check_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 16,
    parameter int unsigned LAT  = 3,
    parameter bit          ODD  = 1'b0,
    localparam int unsigned IW  = $clog2(NREQ),
    localparam int unsigned CW  = (LAT > 1) ? $clog2(LAT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic               done,
    output logic [IW-1:0]      done_id,
    output logic               parity
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic            parity_q, parity_d;
    logic [DW-1:0]   op_q, op_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   winner;
    logic [DW-1:0]   data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = data[i*DW +: DW];
    end

    // First set request searching last+1, last+2, ... with wrap-around.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] w;
        logic [IW-1:0] idx_t;
        logic          hit;
        int unsigned   idx;
        w   = last;
        hit = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx   = (32'(last) + k) % NREQ;
            idx_t = IW'(idx);
            if (!hit && r[idx_t]) begin
                w   = idx_t;
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = rr_pick(req, last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            parity_q  <= 1'b0;
            op_q      <= '0;
            id_q      <= '0;
            last_q    <= IW'(NREQ - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            parity_q  <= parity_d;
            op_q      <= op_d;
            id_q      <= id_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req) state_d = StCalc;
            StCalc:  if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        parity_d  = parity_q;
        op_d      = op_q;
        id_d      = id_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d  = NREQ'(1) << winner;
                    op_d   = data_arr[winner];
                    id_d   = winner;
                    last_d = winner;
                    cnt_d  = CW'(LAT - 1);
                end
            end
            StCalc: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    parity_d  = (^op_q) ^ ODD;
                    done_id_d = id_q;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign parity  = parity_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Bench for parity_check_arbiter: directed scenarios followed by random traffic and resets.
// Expected outputs come from a timestamp-based model of grant/done scheduling.
module tb_parity_check_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned LAT  = 3;
    localparam bit          ODD  = 1'b0;
    localparam int unsigned IW   = $clog2(NREQ);

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               done;
    logic [IW-1:0]      done_id;
    logic               parity;

    parity_check_arbiter #(
        .NREQ(NREQ),
        .DW  (DW),
        .LAT (LAT),
        .ODD (ODD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .gnt    (gnt),
        .busy   (busy),
        .done   (done),
        .done_id(done_id),
        .parity (parity)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: the engine accepts a grant at edge t only if t >= free_at.
    int              free_at = 0;
    int              done_at = 0;
    int              m_last  = NREQ - 1;
    int              p_id    = 0;
    bit              pending = 1'b0;
    logic            p_par   = 1'b0;
    logic [NREQ-1:0] e_gnt   = '0;
    logic            e_done  = 1'b0;
    logic            e_par   = 1'b0;
    logic [IW-1:0]   e_id    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, then compare.
    task automatic step();
        int w;
        @(posedge clk);
        cyc++;
        if (rst) begin
            e_gnt   = '0;
            e_done  = 1'b0;
            e_par   = 1'b0;
            e_id    = '0;
            m_last  = NREQ - 1;
            free_at = cyc + 1;
            pending = 1'b0;
        end else begin
            e_gnt  = '0;
            e_done = 1'b0;
            if (pending && cyc == done_at) begin
                e_done  = 1'b1;
                e_id    = IW'(p_id);
                e_par   = p_par;
                pending = 1'b0;
            end
            if (cyc >= free_at && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                end
                e_gnt[w] = 1'b1;
                m_last   = w;
                p_id     = w;
                p_par    = (($countones(data[w*DW +: DW]) % 2) == 1) ^ ODD;
                pending  = 1'b1;
                done_at  = cyc + LAT;
                free_at  = cyc + LAT + 2;
            end
        end
        #1;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("done", 32'(done), 32'(e_done));
        check("busy", 32'(busy), 32'(cyc + 1 < free_at));
        check("done_id", 32'(done_id), 32'(e_id));
        check("parity", 32'(parity), 32'(e_par));
    endtask

    // Requesters drop req once granted, or re-raise everything when hold_all is set.
    task automatic run(input int n, input bit hold_all);
        repeat (n) begin
            step();
            #1;
            if (hold_all) req = '1;
            else req = req & ~e_gnt;
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        data = '0;
        run(2, 1'b0);
        rst = 1'b0;
        run(2, 1'b0);

        // Single requests, including one with odd data.
        data[0*DW +: DW] = 16'd10;
        req = 4'b0001;
        run(7, 1'b0);
        data[2*DW +: DW] = 16'h0007;
        req = 4'b0100;
        run(8, 1'b0);

        // Operand changes after the grant must not affect the result.
        data[1*DW +: DW] = 16'h0003;
        req = 4'b0010;
        run(1, 1'b0);
        data[1*DW +: DW] = 16'h0001;
        run(7, 1'b0);

        // Reset during CALC abandons the operation; arbitration restarts at requester 0.
        data[3*DW +: DW] = 16'h0001;
        req = 4'b1000;
        run(2, 1'b0);
        rst = 1'b1;
        req = 4'b1010;
        run(1, 1'b0);
        rst = 1'b0;
        run(12, 1'b0);

        // All requesters held from reset release: rotation at LAT+2 spacing.
        rst = 1'b1;
        data = {16'h00ff, 16'h0101, 16'h8000, 16'h0003};
        run(1, 1'b0);
        rst = 1'b0;
        req = '1;
        run(30, 1'b1);
        req = '0;
        run(6, 1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step();
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (e_gnt[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                if ($urandom_range(0, 2) == 0) data[i*DW +: DW] = DW'($urandom);
            end
            rst = ($urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
